// File: rtl/xdma_finish_tracker_mc.sv
// Multi-slot xDMA finish tracker: per-task beat counting, remote FINISH
// matching by dma_id, FINISH forwarding to the previous hop, done reporting.
module xdma_finish_tracker_mc #(
    parameter int unsigned NumSlots  = 4,
    parameter int unsigned IdWidth   = 8,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned LenWidth  = 32,
    parameter int unsigned FinDepth  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [1:0]           start_mode_i,
    input  logic [IdWidth-1:0]   start_id_i,
    input  logic [LenWidth-1:0]  start_len_i,
    input  logic [AddrWidth-1:0] start_prev_i,
    input  logic                 beat_i,
    input  logic [IdWidth-1:0]   beat_id_i,
    input  logic                 fwd_i,
    input  logic [IdWidth-1:0]   fwd_id_i,
    input  logic                 fin_in_valid_i,
    output logic                 fin_in_ready_o,
    input  logic [IdWidth-1:0]   fin_in_id_i,
    output logic                 fin_out_valid_o,
    input  logic                 fin_out_ready_i,
    output logic [IdWidth-1:0]   fin_out_id_o,
    output logic [AddrWidth-1:0] fin_out_addr_o,
    output logic                 done_o,
    output logic [IdWidth-1:0]   done_id_o,
    output logic                 dup_err_o,
    output logic [NumSlots-1:0]  busy_o
);

    localparam int unsigned SlotW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned PtrW  = $clog2(FinDepth);
    localparam int unsigned CntW  = $clog2(FinDepth + 1);

    typedef enum logic [2:0] {
        S_FREE, S_CNT, S_WAIT, S_SEND, S_DONE
    } slot_state_e;

    slot_state_e          state_q [NumSlots];
    logic [IdWidth-1:0]   id_q    [NumSlots];
    logic [LenWidth-1:0]  cnt_q   [NumSlots];
    logic [AddrWidth-1:0] prev_q  [NumSlots];
    logic [1:0]           mode_q  [NumSlots];

    logic [IdWidth-1:0] fifo_mem [FinDepth];
    logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]    fcnt_q;
    logic               fifo_full, fifo_empty, fifo_push;
    logic [IdWidth-1:0] fifo_head;

    logic             lock_q;
    logic [SlotW-1:0] lock_slot_q;
    logic             dup_err_q;

    logic             free_any, dup_hit, alloc;
    logic [SlotW-1:0] alloc_idx;
    logic             send_any, done_any, match_any;
    logic [SlotW-1:0] send_idx, done_idx, match_idx;
    logic             send_hs;

    assign fifo_full  = (fcnt_q == CntW'(FinDepth));
    assign fifo_empty = (fcnt_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign fifo_push  = fin_in_valid_i & ~fifo_full;

    // Priority pickers: lowest index wins for alloc, FINISH send and done.
    always_comb begin
        free_any  = 1'b0;
        alloc_idx = '0;
        dup_hit   = 1'b0;
        send_any  = 1'b0;
        send_idx  = '0;
        done_any  = 1'b0;
        done_idx  = '0;
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (state_q[i] == S_FREE) begin
                free_any  = 1'b1;
                alloc_idx = SlotW'(i);
            end
            if (state_q[i] == S_SEND) begin
                send_any = 1'b1;
                send_idx = SlotW'(i);
            end
            if (state_q[i] == S_DONE) begin
                done_any = 1'b1;
                done_idx = SlotW'(i);
            end
            if (state_q[i] == S_WAIT && !fifo_empty &&
                id_q[i] == fifo_head) begin
                match_any = 1'b1;
                match_idx = SlotW'(i);
            end
            if (state_q[i] != S_FREE && id_q[i] == start_id_i)
                dup_hit = 1'b1;
        end
        // keep an outstanding FINISH stable until it is accepted
        if (lock_q) begin
            send_any = 1'b1;
            send_idx = lock_slot_q;
        end
    end

    assign start_ready_o   = free_any;
    assign fin_in_ready_o  = ~fifo_full;
    assign alloc           = start_valid_i & free_any & ~dup_hit &
                             (start_mode_i != 2'd3);
    assign fin_out_valid_o = send_any;
    assign fin_out_id_o    = send_any ? id_q[send_idx] : '0;
    assign fin_out_addr_o  = send_any ? prev_q[send_idx] : '0;
    assign send_hs         = send_any & fin_out_ready_i;
    assign done_o          = done_any;
    assign done_id_o       = done_any ? id_q[done_idx] : '0;
    assign dup_err_o       = dup_err_q;

    always_comb begin
        for (int i = 0; i < NumSlots; i++)
            busy_o[i] = (state_q[i] != S_FREE);
    end

    // Per-slot task state machines.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= S_FREE;
                id_q[i]    <= '0;
                cnt_q[i]   <= '0;
                prev_q[i]  <= '0;
                mode_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                unique case (state_q[i])
                    S_FREE: begin
                        if (alloc && alloc_idx == SlotW'(i)) begin
                            id_q[i]    <= start_id_i;
                            cnt_q[i]   <= start_len_i;
                            prev_q[i]  <= start_prev_i;
                            mode_q[i]  <= start_mode_i;
                            state_q[i] <= (start_mode_i == 2'd1) ?
                                          S_WAIT : S_CNT;
                        end
                    end
                    S_CNT: begin
                        if (fwd_i && fwd_id_i == id_q[i] &&
                            mode_q[i] == 2'd2) begin
                            state_q[i] <= S_WAIT;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == '0) begin
                            state_q[i] <= (mode_q[i] == 2'd0) ?
                                          S_DONE : S_SEND;
                        end else if (beat_i && beat_id_i == id_q[i]) begin
                            cnt_q[i] <= cnt_q[i] - 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (match_any && match_idx == SlotW'(i))
                            state_q[i] <= (mode_q[i] == 2'd1) ?
                                          S_DONE : S_SEND;
                    end
                    S_SEND: begin
                        if (send_hs && send_idx == SlotW'(i))
                            state_q[i] <= S_DONE;
                    end
                    S_DONE: begin
                        if (done_idx == SlotW'(i))
                            state_q[i] <= S_FREE;
                    end
                    default: state_q[i] <= S_FREE;
                endcase
            end
        end
    end

    // Outgoing FINISH lock and duplicate-start error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            lock_slot_q <= '0;
            dup_err_q   <= 1'b0;
        end else begin
            lock_q      <= send_any & ~fin_out_ready_i;
            lock_slot_q <= send_idx;
            dup_err_q   <= start_valid_i & free_any & dup_hit;
        end
    end

    // Incoming FINISH FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (fifo_push)
                wr_ptr_q <= (wr_ptr_q == PtrW'(FinDepth - 1)) ?
                            '0 : wr_ptr_q + 1'b1;
            if (match_any)
                rd_ptr_q <= (rd_ptr_q == PtrW'(FinDepth - 1)) ?
                            '0 : rd_ptr_q + 1'b1;
            fcnt_q <= fcnt_q + CntW'(fifo_push) - CntW'(match_any);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i) begin
        if (fifo_push)
            fifo_mem[wr_ptr_q] <= fin_in_id_i;
    end

endmodule

// File: tb/tb_xdma_finish_tracker_mc.sv
// Bench for xdma_finish_tracker_mc: directed scenarios plus random traffic
// compared each cycle against a task-level reference model.
module tb_xdma_finish_tracker_mc;

    localparam int NS    = 4;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_valid_i;
    logic        start_ready_o;
    logic [1:0]  start_mode_i;
    logic [7:0]  start_id_i;
    logic [31:0] start_len_i;
    logic [47:0] start_prev_i;
    logic        beat_i;
    logic [7:0]  beat_id_i;
    logic        fwd_i;
    logic [7:0]  fwd_id_i;
    logic        fin_in_valid_i;
    logic        fin_in_ready_o;
    logic [7:0]  fin_in_id_i;
    logic        fin_out_valid_o;
    logic        fin_out_ready_i;
    logic [7:0]  fin_out_id_o;
    logic [47:0] fin_out_addr_o;
    logic        done_o;
    logic [7:0]  done_id_o;
    logic        dup_err_o;
    logic [3:0]  busy_o;

    xdma_finish_tracker_mc dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
        .start_mode_i(start_mode_i), .start_id_i(start_id_i),
        .start_len_i(start_len_i), .start_prev_i(start_prev_i),
        .beat_i(beat_i), .beat_id_i(beat_id_i),
        .fwd_i(fwd_i), .fwd_id_i(fwd_id_i),
        .fin_in_valid_i(fin_in_valid_i), .fin_in_ready_o(fin_in_ready_o),
        .fin_in_id_i(fin_in_id_i),
        .fin_out_valid_o(fin_out_valid_o), .fin_out_ready_i(fin_out_ready_i),
        .fin_out_id_o(fin_out_id_o), .fin_out_addr_o(fin_out_addr_o),
        .done_o(done_o), .done_id_o(done_id_o),
        .dup_err_o(dup_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one record per task slot, tasks described by
    // what they still wait for.
    localparam int W_BEATS  = 0;
    localparam int W_REMOTE = 1;
    localparam int W_HOP    = 2;
    localparam int W_REPORT = 3;

    bit          t_live [NS];
    int          t_wait [NS];
    int          t_left [NS];
    int          t_kind [NS];
    logic [7:0]  t_id   [NS];
    logic [47:0] t_prev [NS];
    logic [7:0]  fins [$];
    int          hop_hold;
    bit          m_dup;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) t_live[i] = 0;
        fins.delete();
        hop_hold = -1;
        m_dup = 0;
    endfunction

    function automatic int pick_hop();
        if (hop_hold >= 0) return hop_hold;
        for (int i = 0; i < NS; i++)
            if (t_live[i] && t_wait[i] == W_HOP) return i;
        return -1;
    endfunction

    function automatic int pick_report();
        for (int i = 0; i < NS; i++)
            if (t_live[i] && t_wait[i] == W_REPORT) return i;
        return -1;
    endfunction

    function automatic void model_step();
        int rep, hop, freei;
        bit dup, popped, can_push;
        logic [3:0] bsy;
        rep = pick_report();
        hop = pick_hop();
        freei = -1;
        dup = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (!t_live[i]) freei = i;
            else if (t_id[i] == start_id_i) dup = 1;
        end
        can_push = fins.size() < DEPTH;
        popped = 0;
        for (int i = 0; i < NS; i++) begin
            if (!t_live[i]) continue;
            case (t_wait[i])
                W_REPORT: if (i == rep) t_live[i] = 0;
                W_HOP: if (i == hop && fin_out_ready_i) t_wait[i] = W_REPORT;
                W_REMOTE:
                    if (fins.size() > 0 && fins[0] == t_id[i]) begin
                        popped = 1;
                        t_wait[i] = (t_kind[i] == 1) ? W_REPORT : W_HOP;
                    end
                default: begin
                    if (fwd_i && fwd_id_i == t_id[i] && t_kind[i] == 2) begin
                        t_wait[i] = W_REMOTE;
                        t_left[i] = 0;
                    end else if (t_left[i] == 0)
                        t_wait[i] = (t_kind[i] == 0) ? W_REPORT : W_HOP;
                    else if (beat_i && beat_id_i == t_id[i])
                        t_left[i]--;
                end
            endcase
        end
        if (popped) void'(fins.pop_front());
        if (fin_in_valid_i && can_push) fins.push_back(fin_in_id_i);
        hop_hold = (hop >= 0 && !fin_out_ready_i) ? hop : -1;
        m_dup = start_valid_i && freei >= 0 && dup;
        if (start_valid_i && freei >= 0 && !dup && start_mode_i != 2'd3) begin
            t_live[freei] = 1;
            t_id[freei]   = start_id_i;
            t_kind[freei] = start_mode_i;
            t_left[freei] = start_len_i;
            t_prev[freei] = start_prev_i;
            t_wait[freei] = (start_mode_i == 2'd1) ? W_REMOTE : W_BEATS;
        end
        bsy = '0;
    endfunction

    task automatic compare_outputs();
        int rep, hop;
        bit anyfree;
        logic [3:0] bsy;
        rep = pick_report();
        hop = pick_hop();
        anyfree = 0;
        for (int i = 0; i < NS; i++) begin
            bsy[i] = t_live[i];
            if (!t_live[i]) anyfree = 1;
        end
        chk("start_ready", start_ready_o, anyfree);
        chk("fin_in_ready", fin_in_ready_o, fins.size() < DEPTH);
        chk("busy", busy_o, bsy);
        chk("dup_err", dup_err_o, m_dup);
        chk("done", done_o, rep >= 0);
        if (rep >= 0) chk("done_id", done_id_o, t_id[rep]);
        chk("fin_out_valid", fin_out_valid_o, hop >= 0);
        if (hop >= 0) begin
            chk("fin_out_id", fin_out_id_o, t_id[hop]);
            chk("fin_out_addr", fin_out_addr_o, t_prev[hop]);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        compare_outputs();
        if (rst_ni) model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        start_valid_i = 0; start_mode_i = 0; start_id_i = 0;
        start_len_i = 0; start_prev_i = 0;
        beat_i = 0; beat_id_i = 0; fwd_i = 0; fwd_id_i = 0;
        fin_in_valid_i = 0; fin_in_id_i = 0; fin_out_ready_i = 1;
    endtask

    task automatic idles(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [1:0] m, input logic [7:0] id,
                         input logic [31:0] len, input logic [47:0] prev);
        idle();
        start_valid_i = 1; start_mode_i = m; start_id_i = id;
        start_len_i = len; start_prev_i = prev;
        tick();
    endtask

    task automatic beat(input logic [7:0] id);
        idle(); beat_i = 1; beat_id_i = id; tick();
    endtask

    task automatic fin(input logic [7:0] id);
        idle(); fin_in_valid_i = 1; fin_in_id_i = id; tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, start_ready_o, 1);
        chk({tag, "_fin_in_ready"}, fin_in_ready_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_done_id"}, done_id_o, 0);
        chk({tag, "_dup"}, dup_err_o, 0);
        chk({tag, "_fo_valid"}, fin_out_valid_o, 0);
        chk({tag, "_fo_id"}, fin_out_id_o, 0);
        chk({tag, "_fo_addr"}, fin_out_addr_o, 0);
    endtask

    initial begin
        idle();
        model_reset();
        #3;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;

        // READ id=5 len=3
        start(2'd0, 8'd5, 32'd3, 48'd0);
        idles(1);
        beat(8'd5); beat(8'd5); beat(8'd5);
        idles(4);

        // WRITE_FIRST id=2
        start(2'd1, 8'd2, 32'd0, 48'd0);
        fin(8'd2);
        idles(4);

        // WRITE_LAST id=7 with a slow previous hop
        start(2'd2, 8'd7, 32'd2, 48'h1000);
        beat(8'd7); beat(8'd7);
        idle(); fin_out_ready_i = 0;
        for (int i = 0; i < 7; i++) tick();
        idles(4);

        // middle hop id=9
        start(2'd2, 8'd9, 32'd3, 48'h2000);
        beat(8'd9);
        idle(); fwd_i = 1; fwd_id_i = 8'd9; tick();
        beat(8'd9); beat(8'd9);
        idles(2);
        fin(8'd9);
        idles(5);

        // fill slots, duplicate, stall
        start(2'd1, 8'd10, 0, 0);
        start(2'd1, 8'd11, 0, 0);
        start(2'd1, 8'd12, 0, 0);
        start(2'd1, 8'd10, 0, 0);
        start(2'd1, 8'd13, 0, 0);
        start(2'd0, 8'd14, 1, 0);
        start(2'd0, 8'd11, 1, 0);
        fin(8'd10); fin(8'd11); fin(8'd12); fin(8'd13);
        idles(6);

        // orphan FINISH tokens fill the FIFO, then get claimed
        fin(8'd3); fin(8'd3); fin(8'd3); fin(8'd3); fin(8'd3);
        for (int k = 0; k < 4; k++) begin
            start(2'd1, 8'd3, 0, 0);
            idles(4);
        end

        // random traffic with one reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_ni = 0;
                #1;
                model_reset();
                check_reset_outputs("midrst");
                idles(2);
                rst_ni = 1;
            end
            start_valid_i  = ($urandom_range(0, 2) == 0);
            start_mode_i   = 2'($urandom_range(0, 3));
            start_id_i     = 8'($urandom_range(0, 7));
            start_len_i    = 32'($urandom_range(0, 3));
            start_prev_i   = {16'($urandom), 32'($urandom)};
            beat_i         = $urandom_range(0, 1);
            beat_id_i      = 8'($urandom_range(0, 7));
            fwd_i          = ($urandom_range(0, 7) == 0);
            fwd_id_i       = 8'($urandom_range(0, 7));
            fin_in_valid_i = ($urandom_range(0, 3) == 0);
            fin_in_id_i    = 8'($urandom_range(0, 7));
            fin_out_ready_i = $urandom_range(0, 1);
            tick();
        end
        idles(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
